// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers pixel coordinates, the active-video window and timing lock from a VGA sync stream.
// Latency: every output is exactly 4 clk_in cycles behind the pins (2-flop sync, edge register, output register).
// Backpressure: none. This is a free-running pixel stream with one sample per clock and no stall path.
//
// Ports:
//   clk_in, reset               pixel clock and synchronous active-high reset
//   h_sync, v_sync              active-low syncs as seen on the cable
//   r_in, g_in, b_in            1-bit pixel colour
//   h_count, v_count            recovered column/row (0 outside the active window)
//   display_en                  active pixel while locked
//   r_out, g_out, b_out         colour aligned to the counts, masked by display_en
//   locked, line_len            timing verified; clocks between the last two hsync falls
//   frame_lines, err_cnt        lines in the last frame; lock-loss events (saturating)
module vga_timing_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        r_in,
    input  logic        g_in,
    input  logic        b_in,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        display_en,
    output logic        r_out,
    output logic        g_out,
    output logic        b_out,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_cnt
);

    localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] TIMEOUT_C = 11'(2 * H_TOTAL);
    localparam logic [9:0]  V_START_C = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END_C   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  V_TOTAL_C = 10'(V_TOTAL);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        meas_first, first_nxt;   // next hsync fall is the first since entering MEASURE
    logic        meas_bad, bad_nxt;       // a bad line was seen during this MEASURE frame
    logic        err_inc;
    logic        line_bad;

    logic        hs_s1, hs_s2, hs_prev, h_fall;
    logic        vs_s1, vs_s2, vs_prev, v_fall;
    logic [2:0]  rgb_d1, rgb_d2, rgb_d3;

    logic [10:0] h_pos, h_pos_nxt, line_len_new;
    logic [9:0]  v_pos, v_pos_nxt, frame_new;
    logic        h_act, v_act, line_ok, frame_ok, timeout, lock_nxt;

    // Position counters and measurements, evaluated on the registered edges.
    always_comb begin
        h_pos_nxt    = h_fall ? 11'd0 : ((h_pos == 11'h7ff) ? h_pos : h_pos + 11'd1);
        line_len_new = (h_pos == 11'h7ff) ? 11'h7ff : h_pos + 11'd1;
        frame_new    = (v_pos == 10'h3ff) ? 10'h3ff : v_pos + 10'd1;
        v_pos_nxt    = v_pos;
        // A coincident vsync fall wins: the frame restarts at row 0 with no extra increment.
        if (v_fall) begin
            v_pos_nxt = 10'd0;
        end else if (h_fall && v_pos != 10'h3ff) begin
            v_pos_nxt = v_pos + 10'd1;
        end
        line_ok  = (line_len_new == H_TOTAL_C);
        frame_ok = (frame_new == V_TOTAL_C);
        // Fires once per stall: h_pos keeps counting past the threshold.
        timeout  = !h_fall && (h_pos_nxt == TIMEOUT_C);
        h_act    = (h_pos_nxt >= H_START_C) && (h_pos_nxt < H_END_C);
        v_act    = (v_pos_nxt >= V_START_C) && (v_pos_nxt < V_END_C);
    end

    // Lock state machine: next state.
    always_comb begin
        state_nxt = state;
        first_nxt = meas_first;
        bad_nxt   = meas_bad;
        err_inc   = 1'b0;
        line_bad  = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_nxt = MEASURE;
                    first_nxt = 1'b1;
                    bad_nxt   = 1'b0;
                end
            end
            MEASURE: begin
                // The first line after entry may be partial, so it is not judged.
                line_bad = h_fall && !meas_first && !line_ok;
                if (h_fall) first_nxt = 1'b0;
                if (line_bad) bad_nxt = 1'b1;
                if (v_fall) begin
                    state_nxt = (frame_ok && !meas_bad && !line_bad) ? LOCKED : SEARCH;
                end
            end
            LOCKED: begin
                if ((h_fall && !line_ok) || (v_fall && !frame_ok)) begin
                    state_nxt = SEARCH;
                    err_inc   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (timeout) begin
            state_nxt = SEARCH;
            if (state == LOCKED) err_inc = 1'b1;
        end
        lock_nxt = (state_nxt == LOCKED);
    end

    // Lock state machine: state register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= SEARCH;
            meas_first <= 1'b0;
            meas_bad   <= 1'b0;
        end else begin
            state      <= state_nxt;
            meas_first <= first_nxt;
            meas_bad   <= bad_nxt;
        end
    end

    // Input pipeline, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            hs_s1       <= 1'b1;
            hs_s2       <= 1'b1;
            hs_prev     <= 1'b1;
            h_fall      <= 1'b0;
            vs_s1       <= 1'b1;
            vs_s2       <= 1'b1;
            vs_prev     <= 1'b1;
            v_fall      <= 1'b0;
            rgb_d1      <= 3'd0;
            rgb_d2      <= 3'd0;
            rgb_d3      <= 3'd0;
            h_pos       <= 11'd0;
            v_pos       <= 10'd0;
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            display_en  <= 1'b0;
            r_out       <= 1'b0;
            g_out       <= 1'b0;
            b_out       <= 1'b0;
            locked      <= 1'b0;
            line_len    <= 11'd0;
            frame_lines <= 10'd0;
            err_cnt     <= 8'd0;
        end else begin
            hs_s1   <= h_sync;
            hs_s2   <= hs_s1;
            hs_prev <= hs_s2;
            h_fall  <= hs_prev & ~hs_s2;
            vs_s1   <= v_sync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
            v_fall  <= vs_prev & ~vs_s2;
            rgb_d1  <= {r_in, g_in, b_in};
            rgb_d2  <= rgb_d1;
            rgb_d3  <= rgb_d2;

            h_pos <= h_pos_nxt;
            v_pos <= v_pos_nxt;
            if (h_fall) line_len <= line_len_new;
            if (v_fall) frame_lines <= frame_new;
            if (err_inc && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;

            locked     <= lock_nxt;
            display_en <= lock_nxt & h_act & v_act;
            h_count    <= h_act ? 10'(h_pos_nxt - H_START_C) : 10'd0;
            v_count    <= v_act ? (v_pos_nxt - V_START_C) : 10'd0;
            r_out      <= lock_nxt & h_act & v_act & rgb_d3[2];
            g_out      <= lock_nxt & h_act & v_act & rgb_d3[1];
            b_out      <= lock_nxt & h_act & v_act & rgb_d3[0];
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: directed bench for vga_timing_decoder on a scaled-down mode.
// Mode: 32 clocks/line (sync 4, back 4, active 16), 16 lines/frame (sync 2, back 3, active 8).
// Pixel presented at cycle c is visible on the outputs at the falling edge of cycle c+4.
module tb_vga_timing_decoder;

    localparam int HS = 4;
    localparam int VS = 2;
    localparam int XA0 = 8;
    localparam int XA1 = 24;
    localparam int YA0 = 5;
    localparam int YA1 = 13;

    logic        clk_in;
    logic        reset;
    logic        h_sync, v_sync, r_in, g_in, b_in;
    logic [9:0]  h_count, v_count, frame_lines;
    logic        display_en, r_out, g_out, b_out, locked;
    logic [10:0] line_len;
    logic [7:0]  err_cnt;

    vga_timing_decoder #(
        .H_ACTIVE(16), .H_SYNC(4), .H_BACK(4), .H_TOTAL(32),
        .V_ACTIVE(8), .V_SYNC(2), .V_BACK(3), .V_TOTAL(16)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .h_sync(h_sync), .v_sync(v_sync),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .h_count(h_count), .v_count(v_count), .display_en(display_en),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines), .err_cnt(err_cnt)
    );

    int n_checks, n_fail;
    int cyc, gx, gy, gframe, hfall_y, hfall_cyc;
    int vf [0:31];
    int short_frame, trunc_frame;
    logic gen_en, hold_h, was_hold;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    task automatic wait_frame(input int k, output int c);
        int n = 0;
        while (gframe < k && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        chk($sformatf("frame%0d_seen", k), 32'(gframe >= k), 1);
        c = vf[k];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_de"}, 32'(display_en), 0);
        chk({tag, "_hcount"}, 32'(h_count), 0);
        chk({tag, "_vcount"}, 32'(v_count), 0);
        chk({tag, "_line_len"}, 32'(line_len), 0);
        chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
        chk({tag, "_err"}, 32'(err_cnt), 0);
        chk({tag, "_rgb"}, 32'({r_out, g_out, b_out}), 0);
    endtask

    // Pixel source: one pixel per clock, line starts with hsync low, frame starts with vsync low.
    // Active pixel (0,0) is 101, other active pixels are 000, blanking carries green to test masking.
    initial begin
        int llen, flines;
        logic act;
        h_sync = 1'b1; v_sync = 1'b1; r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
        cyc = 0; gx = 0; gy = 0; gframe = 0; hfall_y = -1; hfall_cyc = 0; was_hold = 1'b0;
        forever begin
            @(posedge clk_in);
            cyc++;
            #1;
            if (!gen_en || hold_h) begin
                h_sync = 1'b1;
                if (!gen_en) v_sync = 1'b1;
                r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
                if (hold_h) was_hold = 1'b1;
            end else begin
                if (was_hold) begin
                    gx = 0; gy = 0; was_hold = 1'b0;
                end
                if (gx == 0 && gy == 0) begin
                    gframe++;
                    if (gframe < 32) vf[gframe] = cyc;
                end
                if (gx == 0) begin
                    hfall_y = gy; hfall_cyc = cyc;
                end
                h_sync = (gx >= HS);
                v_sync = (gy >= VS);
                act  = (gx >= XA0) && (gx < XA1) && (gy >= YA0) && (gy < YA1);
                r_in = act && gx == XA0 && gy == YA0;
                b_in = act && gx == XA0 && gy == YA0;
                g_in = !act;
                llen   = (gframe == short_frame && gy == 10) ? 31 : 32;
                flines = (gframe == trunc_frame) ? 15 : 16;
                gx++;
                if (gx == llen) begin
                    gx = 0; gy++;
                    if (gy == flines) gy = 0;
                end
            end
        end
    end

    initial begin
        int c2, c3, c4, c5, c6, c8, c9, c10, c11, c12, ch, lk, n;
        int de_tot, runs, run, max_run, min_run, rgb_bad, hits, lock_drop;
        logic exp_px;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; gen_en = 1'b0; hold_h = 1'b0; short_frame = -1; trunc_frame = -1;
        repeat (5) @(negedge clk_in);
        chk_all_zero("reset");
        reset = 1'b0;
        gen_en = 1'b1;

        // No lock during the first frame; lock 4 clocks after the second vsync fall.
        lk = 0; n = 0;
        while (gframe < 2 && n < 3000) begin
            @(negedge clk_in);
            lk = lk + int'(locked);
            n++;
        end
        chk("frame2_seen", 32'(gframe >= 2), 1);
        c2 = vf[2];
        while (cyc < c2 + 3) begin
            @(negedge clk_in);
            lk = lk + int'(locked);
        end
        chk("no_early_lock", 32'(lk), 0);
        @(negedge clk_in);
        chk("lock_rise", 32'(locked), 1);
        chk("line_len_good", 32'(line_len), 32);
        chk("frame_lines_good", 32'(frame_lines), 16);
        chk("err_zero", 32'(err_cnt), 0);
        short_frame = 3;

        // Scan frame 2 entirely while locked.
        de_tot = 0; runs = 0; run = 0; max_run = 0; min_run = 1000;
        rgb_bad = 0; hits = 0; lock_drop = 0;
        for (int t = 0; t < 512; t++) begin
            if (display_en) begin
                de_tot++; run++;
            end else if (run > 0) begin
                runs++;
                if (run > max_run) max_run = run;
                if (run < min_run) min_run = run;
                run = 0;
            end
            exp_px = display_en && (h_count == 10'd0) && (v_count == 10'd0);
            if (r_out !== exp_px || b_out !== exp_px || g_out !== 1'b0) rgb_bad++;
            if (r_out && b_out) hits++;
            if (!locked) lock_drop++;
            if (t == 7 * 32 + 20) begin
                chk("hcount_mid", 32'(h_count), 12);
                chk("vcount_mid", 32'(v_count), 2);
                chk("de_mid", 32'(display_en), 1);
            end
            if (t == 5 * 32 + 7) chk("de_before_active", 32'(display_en), 0);
            if (t == 5 * 32 + 23) chk("hcount_last", 32'(h_count), 15);
            if (t == 5 * 32 + 24) chk("de_after_active", 32'(display_en), 0);
            if (t == 12 * 32 + 10) chk("vcount_last", 32'(v_count), 7);
            if (t == 13 * 32 + 10) chk("de_below_active", 32'(display_en), 0);
            @(negedge clk_in);
        end
        chk("de_total", 32'(de_tot), 128);
        chk("de_lines", 32'(runs), 8);
        chk("de_run_max", 32'(max_run), 16);
        chk("de_run_min", 32'(min_run), 16);
        chk("rgb_align_errs", 32'(rgb_bad), 0);
        chk("rgb_pixel_hits", 32'(hits), 1);
        chk("lock_held", 32'(lock_drop), 0);

        // Frame 3: line 10 is 31 clocks; the fall ending it is at line 11 start.
        wait_frame(3, c3);
        wait_to(c3 + 351 + 3);
        chk("short_still_locked", 32'(locked), 1);
        @(negedge clk_in);
        chk("short_unlock", 32'(locked), 0);
        chk("short_err", 32'(err_cnt), 1);
        chk("short_line_len", 32'(line_len), 31);
        wait_frame(4, c4);
        wait_to(c4 + 4);
        chk("measure_unlocked", 32'(locked), 0);
        trunc_frame = 5;
        wait_frame(5, c5);
        wait_to(c5 + 3);
        chk("relock1_pre", 32'(locked), 0);
        @(negedge clk_in);
        chk("relock1", 32'(locked), 1);
        chk("relock1_err", 32'(err_cnt), 1);

        // Frame 5 has only 15 lines.
        wait_frame(6, c6);
        wait_to(c6 + 3);
        chk("trunc_pre", 32'(locked), 1);
        @(negedge clk_in);
        chk("trunc_unlock", 32'(locked), 0);
        chk("trunc_frame_lines", 32'(frame_lines), 15);
        chk("trunc_err", 32'(err_cnt), 2);
        wait_frame(8, c8);
        wait_to(c8 + 4);
        chk("relock2", 32'(locked), 1);

        // Hold hsync high right after the fall starting line 3.
        n = 0;
        while (!(hfall_y == 3 && hfall_cyc > c8) && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        chk("line3_seen", 32'(hfall_y == 3 && hfall_cyc > c8), 1);
        ch = hfall_cyc;
        hold_h = 1'b1;
        wait_to(ch + 67);
        chk("timeout_pre", 32'(locked), 1);
        @(negedge clk_in);
        chk("timeout_unlock", 32'(locked), 0);
        chk("timeout_err", 32'(err_cnt), 3);
        wait_to(ch + 2200);
        hold_h = 1'b0;
        wait_frame(9, c9);
        wait_to(c9 + 4);
        chk("sat_line_len", 32'(line_len), 2047);
        chk("resume_frame_lines", 32'(frame_lines), 4);
        chk("resume_err", 32'(err_cnt), 3);
        chk("resume_unlocked", 32'(locked), 0);
        wait_frame(10, c10);
        wait_to(c10 + 4);
        chk("relock3", 32'(locked), 1);

        // Reset while locked, during an active pixel.
        wait_to(c10 + 5 * 32 + 12);
        reset = 1'b1;
        @(negedge clk_in);
        chk_all_zero("midreset");
        reset = 1'b0;
        wait_frame(11, c11);
        wait_to(c11 + 4);
        chk("post_reset_measure", 32'(locked), 0);
        wait_frame(12, c12);
        wait_to(c12 + 3);
        chk("post_reset_pre", 32'(locked), 0);
        @(negedge clk_in);
        chk("post_reset_lock", 32'(locked), 1);
        chk("post_reset_err", 32'(err_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
